// File: rtl/dual_issue_scheduler_if.sv
// Fetch-to-issue bus of the dual-issue scheduler: the fetched pair with its
// handshake and flush, the two issue lanes, and the stall counter.
interface dual_issue_scheduler_if #(
  parameter int STALL_W = 16
);
  logic               fetch_valid;
  logic [31:0]        fetch_ir0;
  logic [31:0]        fetch_ir1;
  logic               fetch_ready;
  logic               flush;
  logic               issue0_valid;
  logic [31:0]        issue0_ir;
  logic               issue1_valid;
  logic [31:0]        issue1_ir;
  logic [STALL_W-1:0] stall_count;

  // Fetch / front-end side.
  modport master (
    output fetch_valid, fetch_ir0, fetch_ir1, flush,
    input  fetch_ready, issue0_valid, issue0_ir, issue1_valid, issue1_ir,
           stall_count
  );

  // Scheduler side.
  modport slave (
    input  fetch_valid, fetch_ir0, fetch_ir1, flush,
    output fetch_ready, issue0_valid, issue0_ir, issue1_valid, issue1_ir,
           stall_count
  );
endinterface

// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: buffers one aligned fetch pair and issues 0, 1 or 2
// instructions per cycle, splitting on intra-pair hazards, the shared memory
// port and slot-0 control flow, and stalling on load-use via a scoreboard.

// Per-slot decoder: destination/source registers and class flags.
// A register number of 0 means "none" for both dst and sources.
module dis_decode (
  input  logic [31:0] ir,
  output logic [4:0]  dst,
  output logic [4:0]  src0,
  output logic [4:0]  src1,
  output logic        is_lw,
  output logic        is_mem,
  output logic        is_ctrl
);
  localparam logic [5:0] OP_LW = 6'b010000;
  localparam logic [5:0] OP_SW = 6'b010001;
  localparam logic [5:0] OP_J  = 6'b100000;

  logic [5:0] op;
  logic [4:0] rs, rt, rd;
  logic       unused_ok;

  assign op = ir[31:26];
  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign rd = ir[15:11];
  assign unused_ok = ^ir[10:0];

  // Class decode; anything unlisted (including NOP) reads and writes nothing.
  always_comb begin
    dst     = '0;
    src0    = '0;
    src1    = '0;
    is_lw   = 1'b0;
    is_mem  = 1'b0;
    is_ctrl = 1'b0;
    if (op[5:3] == 3'b000) begin
      dst  = rd;
      src0 = rs;
      src1 = rt;
    end else if (op[5:3] == 3'b001) begin
      dst  = rt;
      src0 = rs;
    end else if (op == OP_LW) begin
      dst    = rt;
      src0   = rs;
      is_lw  = 1'b1;
      is_mem = 1'b1;
    end else if (op == OP_SW) begin
      src0   = rs;
      src1   = rt;
      is_mem = 1'b1;
    end else if (op[5:3] == 3'b011) begin
      src0    = rs;
      src1    = rt;
      is_ctrl = 1'b1;
    end else if (op == OP_J) begin
      is_ctrl = 1'b1;
    end
  end
endmodule

module dual_issue_scheduler #(
  parameter int LOAD_LAT = 1,
  parameter int STALL_W  = 16
) (
  input logic                   clk1,
  input logic                   reset,
  dual_issue_scheduler_if.slave bus
);
  localparam int          CNT_W = $clog2(LOAD_LAT + 1);
  localparam logic [31:0] NOP   = {6'b111111, 26'd0};

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PAIR  = 2'd1,
    S_ONE   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            buf0_q, buf0_d;
  logic [31:0]            buf1_q, buf1_d;
  logic                   iss0_v_q, iss0_v_d;
  logic [31:0]            iss0_ir_q, iss0_ir_d;
  logic                   iss1_v_q, iss1_v_d;
  logic [31:0]            iss1_ir_q, iss1_ir_d;
  logic [31:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [STALL_W-1:0]     stall_q, stall_d;

  // Slot 0 decodes the buffer head, slot 1 the younger instruction.
  logic [1:0][31:0] slot_ir;
  logic [1:0][4:0]  dst, src0, src1;
  logic [1:0]       is_lw, is_mem, is_ctrl;
  logic [1:0]       src_blk;
  logic [31:0]      blk_vec;

  logic head_go, pair_ok, drain, accept, raw, waw;

  assign slot_ir[0] = (state_q == S_ONE) ? buf1_q : buf0_q;
  assign slot_ir[1] = buf1_q;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dec
      dis_decode u_dec (
        .ir      (slot_ir[g]),
        .dst     (dst[g]),
        .src0    (src0[g]),
        .src1    (src1[g]),
        .is_lw   (is_lw[g]),
        .is_mem  (is_mem[g]),
        .is_ctrl (is_ctrl[g])
      );
      assign src_blk[g] = blk_vec[src0[g]] | blk_vec[src1[g]];
    end
  endgenerate

  // Per-register "load in flight" view of the scoreboard; R0 never blocks.
  always_comb begin
    blk_vec = '0;
    for (int r = 1; r < 32; r++) blk_vec[r] = (cnt_q[r] != '0);
  end

  // Issue decision, pairing rules and fetch handshake.
  always_comb begin
    raw     = (dst[0] != 5'd0) && ((src0[1] == dst[0]) || (src1[1] == dst[0]));
    waw     = (dst[0] != 5'd0) && (dst[1] == dst[0]);
    head_go = (state_q != S_EMPTY) && !bus.flush && !src_blk[0];
    pair_ok = (state_q == S_PAIR) && head_go && !raw && !waw &&
              !(is_mem[0] && is_mem[1]) && !is_ctrl[0] && !src_blk[1];
    drain   = ((state_q == S_PAIR) && pair_ok) || ((state_q == S_ONE) && head_go);
    bus.fetch_ready = !bus.flush && ((state_q == S_EMPTY) || drain);
    accept  = bus.fetch_valid && bus.fetch_ready;
  end

  // Buffer FSM next state; a refill overrides whatever the drain left behind.
  always_comb begin
    state_d = state_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    if (bus.flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_PAIR:  if (head_go) state_d = pair_ok ? S_EMPTY : S_ONE;
        S_ONE:   if (head_go) state_d = S_EMPTY;
        default: state_d = S_EMPTY;
      endcase
      if (accept) begin
        state_d = S_PAIR;
        buf0_d  = bus.fetch_ir0;
        buf1_d  = bus.fetch_ir1;
      end
    end
  end

  // Registered issue lanes; an idle lane carries the NOP encoding.
  always_comb begin
    iss0_v_d  = head_go;
    iss0_ir_d = head_go ? slot_ir[0] : NOP;
    iss1_v_d  = pair_ok;
    iss1_ir_d = pair_ok ? buf1_q : NOP;
  end

  // Load scoreboard: an issuing LW arms its destination, others count down.
  always_comb begin
    cnt_d = cnt_q;
    for (int r = 1; r < 32; r++) begin
      if ((head_go && is_lw[0] && (dst[0] == 5'(r))) ||
          (pair_ok && is_lw[1] && (dst[1] == 5'(r))))
        cnt_d[r] = CNT_W'(LOAD_LAT);
      else if (cnt_q[r] != '0)
        cnt_d[r] = cnt_q[r] - 1'b1;
    end
    cnt_d[0] = '0;
  end

  // Saturating stall counter: buffered head held back by a pending load.
  always_comb begin
    stall_d = stall_q;
    if ((state_q != S_EMPTY) && !bus.flush && src_blk[0] && (stall_q != '1))
      stall_d = stall_q + 1'b1;
  end

  // State register.
  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      state_q   <= S_EMPTY;
      buf0_q    <= NOP;
      buf1_q    <= NOP;
      iss0_v_q  <= 1'b0;
      iss0_ir_q <= NOP;
      iss1_v_q  <= 1'b0;
      iss1_ir_q <= NOP;
      cnt_q     <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      iss0_v_q  <= iss0_v_d;
      iss0_ir_q <= iss0_ir_d;
      iss1_v_q  <= iss1_v_d;
      iss1_ir_q <= iss1_ir_d;
      cnt_q     <= cnt_d;
      stall_q   <= stall_d;
    end
  end

  assign bus.issue0_valid = iss0_v_q;
  assign bus.issue0_ir    = iss0_ir_q;
  assign bus.issue1_valid = iss1_v_q;
  assign bus.issue1_ir    = iss1_ir_q;
  assign bus.stall_count  = stall_q;
endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed, table-driven bench for dual_issue_scheduler (LOAD_LAT = 1).
module tb_dual_issue_scheduler;
  localparam logic [31:0] NOP = {6'b111111, 26'd0};

  logic clk1;
  logic reset;
  int   checks;
  int   errors;

  dual_issue_scheduler_if #(.STALL_W(16)) bus ();

  dual_issue_scheduler #(.LOAD_LAT(1), .STALL_W(16)) dut (
    .clk1  (clk1),
    .reset (reset),
    .bus   (bus)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  typedef struct {
    logic        fv;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        fl;
    logic        rdy;
    logic        v0;
    logic [31:0] o0;
    logic        v1;
    logic [31:0] o1;
    logic [15:0] st;
  } vec_t;

  vec_t tbl [21];

  function automatic logic [31:0] add_i(input logic [4:0] rs, rt, rd);
    return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
  endfunction
  function automatic logic [31:0] lw_i(input logic [4:0] rs, rt, input logic [15:0] imm);
    return {6'b010000, rs, rt, imm};
  endfunction
  function automatic logic [31:0] sw_i(input logic [4:0] rs, rt, input logic [15:0] imm);
    return {6'b010001, rs, rt, imm};
  endfunction
  function automatic logic [31:0] beq_i(input logic [4:0] rs, rt, input logic [15:0] imm);
    return {6'b011000, rs, rt, imm};
  endfunction

  function automatic vec_t mk(input logic fv, input logic [31:0] i0, i1, input logic fl,
                              input logic rdy, input logic v0, input logic [31:0] o0,
                              input logic v1, input logic [31:0] o1, input logic [15:0] st);
    vec_t r;
    r.fv = fv; r.i0 = i0; r.i1 = i1; r.fl = fl; r.rdy = rdy;
    r.v0 = v0; r.o0 = o0; r.v1 = v1; r.o1 = o1; r.st = st;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v0, input logic [31:0] o0,
                         input logic v1, input logic [31:0] o1, input logic [15:0] st);
    chk({tag, ".v0"}, 32'(bus.issue0_valid), 32'(v0));
    chk({tag, ".ir0"}, bus.issue0_ir, o0);
    chk({tag, ".v1"}, 32'(bus.issue1_valid), 32'(v1));
    chk({tag, ".ir1"}, bus.issue1_ir, o1);
    chk({tag, ".stall"}, 32'(bus.stall_count), 32'(st));
  endtask

  logic [31:0] a, b, a2, b2, c, d, g, h, i_, j, k, l, m, n, p, q, r, s;

  initial begin
    checks = 0;
    errors = 0;
    a  = add_i(1, 2, 14);  b  = add_i(1, 3, 15);
    a2 = add_i(1, 2, 16);  b2 = add_i(1, 3, 17);
    c  = add_i(1, 2, 14);  d  = add_i(14, 3, 15);
    g  = lw_i(0, 8, 16'd50); h = add_i(1, 7, 19);
    i_ = add_i(1, 8, 20);  j  = add_i(1, 9, 21);
    k  = lw_i(1, 10, 16'd4); l = sw_i(2, 3, 16'd8);
    m  = beq_i(1, 2, 16'd4); n = add_i(1, 2, 22);
    p  = lw_i(0, 8, 16'd7);  q = add_i(8, 1, 23);
    r  = add_i(8, 1, 24);  s  = add_i(1, 2, 25);

    // Each row: inputs for one cycle, fetch_ready in that cycle, outputs after its edge.
    // Independent pairs stream with dual issue and no bubble.
    tbl[0]  = mk(1, a,  b,  0, 1, 0, NOP, 0, NOP, 0);
    tbl[1]  = mk(1, a2, b2, 0, 1, 1, a,   1, b,   0);
    tbl[2]  = mk(0, 0,  0,  0, 1, 1, a2,  1, b2,  0);
    tbl[3]  = mk(0, 0,  0,  0, 1, 0, NOP, 0, NOP, 0);
    // Intra-pair RAW splits; fetch held off while ir1 remains.
    tbl[4]  = mk(1, c,  d,  0, 1, 0, NOP, 0, NOP, 0);
    tbl[5]  = mk(1, a2, b2, 0, 0, 1, c,   0, NOP, 0);
    tbl[6]  = mk(1, a2, b2, 0, 1, 1, d,   0, NOP, 0);
    tbl[7]  = mk(0, 0,  0,  0, 1, 1, a2,  1, b2,  0);
    tbl[8]  = mk(0, 0,  0,  0, 1, 0, NOP, 0, NOP, 0);
    // Load-use: one bubble after LW, counted as a stall.
    tbl[9]  = mk(1, g,  h,  0, 1, 0, NOP, 0, NOP, 0);
    tbl[10] = mk(1, i_, j,  0, 1, 1, g,   1, h,   0);
    tbl[11] = mk(0, 0,  0,  0, 0, 0, NOP, 0, NOP, 1);
    tbl[12] = mk(0, 0,  0,  0, 1, 1, i_,  1, j,   1);
    tbl[13] = mk(0, 0,  0,  0, 1, 0, NOP, 0, NOP, 1);
    // LW/SW share the memory port.
    tbl[14] = mk(1, k,  l,  0, 1, 0, NOP, 0, NOP, 1);
    tbl[15] = mk(0, 0,  0,  0, 0, 1, k,   0, NOP, 1);
    tbl[16] = mk(0, 0,  0,  0, 1, 1, l,   0, NOP, 1);
    // Branch in slot 0 issues alone, then flush kills the younger ADD.
    tbl[17] = mk(1, m,  n,  0, 1, 0, NOP, 0, NOP, 1);
    tbl[18] = mk(0, 0,  0,  0, 0, 1, m,   0, NOP, 1);
    tbl[19] = mk(1, a,  b,  1, 0, 0, NOP, 0, NOP, 1);
    tbl[20] = mk(0, 0,  0,  0, 1, 0, NOP, 0, NOP, 1);

    reset = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.fetch_ir0 = '0;
    bus.fetch_ir1 = '0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk1);
    #1;
    chk_out("reset", 0, NOP, 0, NOP, 0);
    chk("reset.ready", 32'(bus.fetch_ready), 32'd1);
    @(negedge clk1);
    reset = 1'b1;

    for (int t = 0; t < 21; t++) begin
      @(negedge clk1);
      bus.fetch_valid = tbl[t].fv;
      bus.fetch_ir0   = tbl[t].i0;
      bus.fetch_ir1   = tbl[t].i1;
      bus.flush       = tbl[t].fl;
      #1;
      chk($sformatf("row%0d.ready", t), 32'(bus.fetch_ready), 32'(tbl[t].rdy));
      @(posedge clk1);
      #1;
      chk_out($sformatf("row%0d", t), tbl[t].v0, tbl[t].o0, tbl[t].v1, tbl[t].o1, tbl[t].st);
    end

    // Reset while in ONE with a load pending on R8.
    @(negedge clk1);
    bus.fetch_valid = 1'b1;
    bus.fetch_ir0 = p;
    bus.fetch_ir1 = q;
    bus.flush = 1'b0;
    @(posedge clk1);
    @(negedge clk1);
    bus.fetch_valid = 1'b0;
    #1;
    chk("rst1.ready", 32'(bus.fetch_ready), 32'd0);
    @(posedge clk1);
    #1;
    chk_out("rst1.lw", 1, p, 0, NOP, 1);
    #1;
    reset = 1'b0;
    #1;
    chk_out("rst1.async", 0, NOP, 0, NOP, 0);
    @(negedge clk1);
    reset = 1'b1;
    bus.fetch_valid = 1'b1;
    bus.fetch_ir0 = r;
    bus.fetch_ir1 = s;
    #1;
    chk("rst1.ready2", 32'(bus.fetch_ready), 32'd1);
    @(posedge clk1);
    @(negedge clk1);
    bus.fetch_valid = 1'b0;
    #1;
    chk("rst1.ready3", 32'(bus.fetch_ready), 32'd1);
    @(posedge clk1);
    #1;
    chk_out("rst1.pair", 1, r, 1, s, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
